sram_rmw_ctrl: RTL and testbench

SRAM_RMW_CTRL -- requirements
Module: sram_rmw_ctrl

---
 rtl/sram_rmw_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_sram_rmw_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rmw_ctrl.sv
// sram_rmw_ctrl: single-port SRAM controller for read, write, increment and
// read-and-clear requests. Strobes are held for a minimum pulse width and
// until the SRAM acknowledges. A fixed idle gap separates consecutive strobes.
// Every output comes straight from a flop.
module sram_rmw_ctrl #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 12,
  parameter int PULSE_CYC = 2,
  parameter int PRE_CYC   = 2,
  parameter int SATURATE  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 rsp_ovf,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_din,
  input  logic [DATA_BITS-1:0] mem_dout,
  input  logic                 mem_read_done,
  input  logic                 mem_write_done
);

  localparam int CNT_MAX = (PULSE_CYC > PRE_CYC) ? PULSE_CYC : PRE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PULSE_N  = CNT_W'(PULSE_CYC);
  localparam logic [CNT_W-1:0] PRE_N    = CNT_W'(PRE_CYC);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_INC = 2'b10;
  localparam logic [1:0] OP_RCL = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_GAP, S_WRITE, S_PRE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [DATA_BITS-1:0] old_q, old_d;
  logic                 ovf_q, ovf_d;

  logic                 req_ready_q, req_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [DATA_BITS-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_ovf_q, rsp_ovf_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_BITS-1:0] mem_din_q, mem_din_d;

  logic                 accept, rd_exit, wr_exit;
  logic                 dout_max;
  logic [DATA_BITS-1:0] inc_val;

  assign dout_max = &mem_dout;
  assign inc_val  = dout_max ? ((SATURATE != 0) ? {DATA_BITS{1'b1}} : {DATA_BITS{1'b0}})
                             : mem_dout + DATA_BITS'(1);

  // State and output registers; reset parks in PRE so ready rises PRE_CYC cycles after release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_PRE;
      cnt_q       <= PRE_N;
      op_q        <= OP_RD;
      old_q       <= '0;
      ovf_q       <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      old_q       <= old_d;
      ovf_q       <= ovf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
    end
  end

  // Next state: cnt counts strobe cycles up in READ/WRITE and idle cycles down in GAP/PRE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    rd_exit = 1'b0;
    wr_exit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          accept  = 1'b1;
          state_d = (req_op == OP_WR) ? S_WRITE : S_READ;
          cnt_d   = CNT_ONE;
        end
      end
      S_READ: begin
        if (cnt_q >= PULSE_N && mem_read_done) begin
          rd_exit = 1'b1;
          if (op_q == OP_RD) begin
            state_d = (PRE_CYC > 1) ? S_PRE : S_IDLE;
            cnt_d   = PRE_LAST;
          end else begin
            state_d = S_GAP;
            cnt_d   = PRE_N;
          end
        end else if (cnt_q < PULSE_N) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_GAP: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_WRITE;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WRITE: begin
        if (cnt_q >= PULSE_N && mem_write_done) begin
          wr_exit = 1'b1;
          state_d = (PRE_CYC > 1) ? S_PRE : S_IDLE;
          cnt_d   = PRE_LAST;
        end else if (cnt_q < PULSE_N) begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_PRE: begin
        if (cnt_q <= CNT_ONE) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_PRE;
        cnt_d   = PRE_N;
      end
    endcase
  end

  // Outputs: strobes/ready follow the next state; data path latches on accept and strobe exits
  always_comb begin
    req_ready_d = (state_d == S_IDLE);
    mem_read_d  = (state_d == S_READ);
    mem_write_d = (state_d == S_WRITE);
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    op_d        = op_q;
    old_d       = old_q;
    ovf_d       = ovf_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    if (accept) begin
      mem_addr_d = req_addr;
      op_d       = req_op;
      ovf_d      = 1'b0;
      if (req_op == OP_WR) begin
        mem_din_d = req_wdata;
      end
    end
    if (rd_exit) begin
      old_d = mem_dout;
      ovf_d = (op_q == OP_INC) && dout_max;
      if (op_q == OP_RD) begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_dout;
        rsp_ovf_d   = 1'b0;
      end else begin
        mem_din_d = (op_q == OP_RCL) ? {DATA_BITS{1'b0}} : inc_val;
      end
    end
    if (wr_exit) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = (op_q == OP_RCL) ? old_q : mem_din_q;
      rsp_ovf_d   = ovf_q;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// Bench for sram_rmw_ctrl: SRAM responder model, request-level reference
// model, and a per-cycle compare process. A second instance with SATURATE=0
// shares all inputs and is checked against the wrapping increment rule.
module tb_sram_rmw_ctrl;
  localparam int AW  = 6;
  localparam int DW  = 12;
  localparam int PC  = 2;
  localparam int PRC = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [1:0]    req_op = 2'b00;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [DW-1:0] mem_dout = '0;
  logic          mem_read_done = 1'b0;
  logic          mem_write_done = 1'b0;

  logic          req_ready, rsp_valid, rsp_ovf, mem_read, mem_write;
  logic [DW-1:0] rsp_data, mem_din;
  logic [AW-1:0] mem_addr;

  logic          w_req_ready, w_rsp_valid, w_rsp_ovf, w_mem_read, w_mem_write;
  logic [DW-1:0] w_rsp_data, w_mem_din;
  logic [AW-1:0] w_mem_addr;

  sram_rmw_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW), .PULSE_CYC(PC), .PRE_CYC(PRC), .SATURATE(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_read_done(mem_read_done),
    .mem_write_done(mem_write_done));

  sram_rmw_ctrl #(.ADDR_BITS(AW), .DATA_BITS(DW), .PULSE_CYC(PC), .PRE_CYC(PRC), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(w_req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(w_rsp_valid), .rsp_data(w_rsp_data),
    .rsp_ovf(w_rsp_ovf), .mem_read(w_mem_read), .mem_write(w_mem_write), .mem_addr(w_mem_addr),
    .mem_din(w_mem_din), .mem_dout(mem_dout), .mem_read_done(mem_read_done),
    .mem_write_done(mem_write_done));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [DW-1:0] d;
    logic          o;
    logic [DW-1:0] w;
    int            c;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  logic [DW-1:0] sram    [0:(1<<AW)-1];

  logic          rand_delay = 1'b0;
  logic          hold_done = 1'b0;
  int            last_gap = -1;
  int            last_lat = -1;
  logic [DW-1:0] last_wrap_data = '0;
  logic [DW-1:0] rsp_hist[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_mem(input int a, input logic [DW-1:0] v);
    ref_mem[a] = v;
    sram[a]    = v;
  endtask

  // Reference model at request level: expected response for both saturate and wrap instances
  task automatic model_accept(input logic [1:0] op, input int a, input logic [DW-1:0] wd);
    exp_t e;
    logic [DW-1:0] old;
    old = ref_mem[a];
    e.c = cyc;
    e.o = 1'b0;
    case (op)
      2'b00: begin e.d = old; e.w = old; end
      2'b01: begin e.d = wd; e.w = wd; ref_mem[a] = wd; end
      2'b10: begin
        if (old == {DW{1'b1}}) begin
          e.d = old; e.w = '0; e.o = 1'b1;
        end else begin
          e.d = old + 1'b1; e.w = old + 1'b1;
        end
        ref_mem[a] = e.d;
      end
      default: begin e.d = old; e.w = old; ref_mem[a] = '0; end
    endcase
    exp_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [1:0] op, input int a, input logic [DW-1:0] wd);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = AW'(a);
    req_wdata = wd;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      chk("accept_timeout", 32'(n), 32'(0));
      req_valid = 1'b0;
      return;
    end
    model_accept(op, a, wd);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = DW'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n >= 500), 32'(0));
  endtask

  task automatic ready_after_release(input string name);
    int n;
    n = 0;
    rst = 1'b0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(n), 32'(PRC));
  endtask

  // SRAM responder: done rises a configurable number of cycles after the strobe and stays high
  initial begin
    int rd_cnt, wr_cnt, rd_dly, wr_dly;
    logic [31:0] r;
    rd_cnt = 0; wr_cnt = 0; rd_dly = 1; wr_dly = 1;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_cnt = 0; wr_cnt = 0;
        mem_read_done = 1'b0; mem_write_done = 1'b0;
      end else begin
        if (mem_read) begin
          rd_cnt++;
          if (rd_cnt == 1) rd_dly = rand_delay ? int'($urandom_range(1, 3)) : 1;
        end else rd_cnt = 0;
        if (mem_write) begin
          wr_cnt++;
          if (wr_cnt == 1) wr_dly = rand_delay ? int'($urandom_range(1, 3)) : 1;
        end else wr_cnt = 0;
        mem_read_done  = mem_read && !hold_done && rd_cnt > rd_dly;
        mem_write_done = mem_write && !hold_done && wr_cnt > wr_dly;
        if (mem_write_done) sram[mem_addr] = mem_din;
      end
      r = $urandom;
      mem_dout = mem_read ? sram[mem_addr] : r[DW-1:0];
    end
  end

  // Compare process: every cycle checks responses against the model plus strobe/address rules
  initial begin
    exp_t e;
    logic [DW-1:0] hold_d, hold_w;
    logic hold_o, prev_strobe, prev_write;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_din;
    int low_run;
    hold_d = '0; hold_w = '0; hold_o = 1'b0;
    prev_strobe = 1'b0; prev_write = 1'b0; prev_addr = '0; prev_din = '0; low_run = -1;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_d = '0; hold_w = '0; hold_o = 1'b0;
        prev_strobe = 1'b0; prev_write = 1'b0; low_run = -1;
        continue;
      end
      chk("strobe_exclusive", 32'(mem_read && mem_write), 32'(0));
      if (req_ready && (mem_read || mem_write)) chk("ready_while_strobe", 32'(1), 32'(0));
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_data), 32'(0));
          chk("unexpected_rsp_valid", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("rsp_data", 32'(rsp_data), 32'(e.d));
          chk("rsp_ovf", 32'(rsp_ovf), 32'(e.o));
          chk("wrap_rsp_valid", 32'(w_rsp_valid), 32'(1));
          chk("wrap_rsp_data", 32'(w_rsp_data), 32'(e.w));
          chk("wrap_rsp_ovf", 32'(w_rsp_ovf), 32'(e.o));
          hold_d = e.d; hold_o = e.o; hold_w = e.w;
          last_lat = cyc - e.c;
          last_wrap_data = w_rsp_data;
          rsp_hist.push_back(rsp_data);
        end
      end else begin
        chk("rsp_hold", {19'd0, rsp_ovf, rsp_data}, {19'd0, hold_o, hold_d});
        chk("wrap_rsp_hold", {18'd0, w_rsp_valid, w_rsp_ovf, w_rsp_data}, {18'd0, 1'b0, hold_o, hold_w});
      end
      if ((mem_read || mem_write) && prev_strobe)
        chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
      if (mem_write && prev_write)
        chk("din_stable", 32'(mem_din), 32'(prev_din));
      if (mem_read || mem_write) begin
        if (!prev_strobe && low_run > 0) begin
          if (low_run < PRC) chk("strobe_gap_min", 32'(low_run), 32'(PRC));
          n_checks++;
          last_gap = low_run;
        end
        low_run = 0;
      end else if (low_run >= 0) begin
        low_run++;
      end
      prev_strobe = mem_read || mem_write;
      prev_write  = mem_write;
      prev_addr   = mem_addr;
      prev_din    = mem_din;
    end
  end

  initial begin
    logic [31:0] r;
    for (int i = 0; i < (1 << AW); i++) begin
      r = $urandom;
      set_mem(i, r[DW-1:0]);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'(0));
    chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset_rsp_data", 32'(rsp_data), 32'(0));
    chk("reset_rsp_ovf", 32'(rsp_ovf), 32'(0));
    chk("reset_strobes", {30'd0, mem_read, mem_write}, 32'(0));
    chk("reset_mem_addr", 32'(mem_addr), 32'(0));
    chk("reset_mem_din", 32'(mem_din), 32'(0));
    ready_after_release("reset_ready_delay");

    // Write then read back, measuring gap and read latency
    issue(2'b01, 3, 12'h5A5);
    issue(2'b00, 3, 12'h000);
    wait_idle();
    chk("wr_rd_data", 32'(rsp_hist[$]), 32'h5A5);
    chk("wr_rd_gap", 32'(last_gap), 32'(2));
    chk("rd_latency", 32'(last_lat), 32'(PC + 1));

    // Increment without overflow
    set_mem(7, 12'h00F);
    issue(2'b10, 7, 12'h000);
    wait_idle();
    chk("inc_data", 32'(rsp_data), 32'h010);
    chk("inc_ovf", 32'(rsp_ovf), 32'(0));
    chk("inc_mem", 32'(sram[7]), 32'h010);
    chk("inc_rd_wr_gap", 32'(last_gap), 32'(2));

    // Increment at all-ones: saturate and wrap instances
    set_mem(7, 12'hFFF);
    issue(2'b10, 7, 12'h000);
    wait_idle();
    chk("sat_data", 32'(rsp_data), 32'hFFF);
    chk("sat_ovf", 32'(rsp_ovf), 32'(1));
    chk("wrap_data", 32'(last_wrap_data), 32'h000);
    chk("wrap_ovf", 32'(w_rsp_ovf), 32'(1));

    // Read-and-clear then read
    set_mem(9, 12'h123);
    issue(2'b11, 9, 12'h000);
    issue(2'b00, 9, 12'h000);
    wait_idle();
    chk("rcl_old", 32'(rsp_hist[rsp_hist.size()-2]), 32'h123);
    chk("rcl_after", 32'(rsp_hist[$]), 32'h000);

    // Stalled read, then reset mid-READ
    hold_done = 1'b1;
    issue(2'b00, 5, 12'h000);
    for (int i = 0; i < 10; i++) begin
      chk("stall_read_high", {30'd0, mem_read, req_ready}, 32'h2);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("rst_drops_read", 32'(mem_read), 32'(0));
    chk("rst_no_rsp", 32'(rsp_valid), 32'(0));
    exp_q.delete();
    hold_done = 1'b0;
    repeat (2) @(negedge clk);
    ready_after_release("rst_mid_ready_delay");

    // Random back-to-back traffic with variable done delay
    rand_delay = 1'b1;
    for (int t = 0; t < 60; t++) begin
      r = $urandom;
      issue(r[1:0], int'(r[5:2]), r[31:20]);
      if (r[7:6] == 2'b00) repeat (int'($urandom_range(1, 3))) @(negedge clk);
    end
    wait_idle();
    for (int i = 0; i < (1 << AW); i++) begin
      if (sram[i] !== ref_mem[i]) chk("final_mem", 32'(sram[i]), 32'(ref_mem[i]));
    end
    n_checks++;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
